// File: rtl/regfile_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bist_pkg
// Description : Shared state codes, default seed and march pattern function
//               for the register-file BIST.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_bist_pkg;

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_WR0  = 3'd1;
   localparam logic [2:0] c_RD0  = 3'd2;
   localparam logic [2:0] c_WR1  = 3'd3;
   localparam logic [2:0] c_RD1  = 3'd4;
   localparam logic [2:0] c_DONE = 3'd5;

   localparam logic [31:0] c_DEF_SEED = 32'hA5A5_5A5A;

   // Computed at 64 bits; callers keep the low DW bits, which is exact
   // because the pattern is purely bitwise.
   function automatic logic [63:0] exp_data(input logic        pass_sel,
                                            input logic [63:0] addr,
                                            input logic [63:0] seed);
      logic [63:0] v;
      v = seed ^ addr;
      if (pass_sel) v = ~v;
      if (addr == 64'd0) v = '0;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bist_cmp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bist_cmp
// Description : Dual read-port comparator; port 1 takes priority on mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bist_cmp #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic [DW-1:0] rd1,
   input  logic [DW-1:0] rd2,
   input  logic [DW-1:0] exp1,
   input  logic [DW-1:0] exp2,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic          mismatch,
   output logic [AW-1:0] fail_addr_next,
   output logic          fail_port_next
);

   logic w_mis1;
   logic w_mis2;

   assign w_mis1         = (rd1 != exp1);
   assign w_mis2         = (rd2 != exp2);
   assign mismatch       = w_mis1 | w_mis2;
   assign fail_addr_next = w_mis1 ? ra1 : ra2;
   assign fail_port_next = ~w_mis1;

endmodule
`default_nettype wire

// File: rtl/regfile_bist.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bist
// Description : Two-pass march BIST (true, then complement) for a 3-port
//               register file, reporting the first failing address and port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bist
   import regfile_bist_pkg::*;
#(
   parameter int          NREG = 32,
   parameter int          AW   = 5,
   parameter int          DW   = 32,
   parameter logic [31:0] SEED = c_DEF_SEED
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   output logic [AW-1:0] ra1,
   output logic [AW-1:0] ra2,
   input  logic [DW-1:0] rd1,
   input  logic [DW-1:0] rd2,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW-1:0] fail_addr,
   output logic          fail_port
);

   localparam logic [AW-1:0] c_LAST = AW'(NREG - 1);

   logic [2:0]    r_state;
   logic [AW-1:0] r_cnt;
   logic          r_done;
   logic          r_pass;
   logic [AW-1:0] r_fail_addr;
   logic          r_fail_port;

   logic          w_wr;
   logic          w_rd;
   logic          w_sel;
   logic          w_last;
   logic [AW-1:0] w_ra1;
   logic [AW-1:0] w_ra2;
   logic [DW-1:0] w_exp1;
   logic [DW-1:0] w_exp2;
   logic          w_mismatch;
   logic [AW-1:0] w_fail_addr_next;
   logic          w_fail_port_next;

   function automatic logic [DW-1:0] exp_dw(input logic sel, input logic [AW-1:0] a);
      return DW'(exp_data(sel, 64'(a), 64'(SEED)));
   endfunction

   // Port drive is a pure decode of state and counter, so it is zero when idle.
   assign w_wr   = (r_state == c_WR0) || (r_state == c_WR1);
   assign w_rd   = (r_state == c_RD0) || (r_state == c_RD1);
   assign w_sel  = (r_state == c_WR1) || (r_state == c_RD1);
   assign w_last = (r_cnt == c_LAST);
   assign w_ra1  = w_rd ? r_cnt : '0;
   assign w_ra2  = w_rd ? (c_LAST - r_cnt) : '0;
   assign w_exp1 = exp_dw(w_sel, w_ra1);
   assign w_exp2 = exp_dw(w_sel, w_ra2);

   assign busy      = w_wr | w_rd;
   assign we3       = w_wr;
   assign wa3       = w_wr ? r_cnt : '0;
   assign wd3       = w_wr ? exp_dw(w_sel, r_cnt) : '0;
   assign ra1       = w_ra1;
   assign ra2       = w_ra2;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail_addr = r_fail_addr;
   assign fail_port = r_fail_port;

   regfile_bist_cmp #(
      .AW (AW),
      .DW (DW)
   ) u_cmp (
      .rd1            (rd1),
      .rd2            (rd2),
      .exp1           (w_exp1),
      .exp2           (w_exp2),
      .ra1            (w_ra1),
      .ra2            (w_ra2),
      .mismatch       (w_mismatch),
      .fail_addr_next (w_fail_addr_next),
      .fail_port_next (w_fail_port_next)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= c_IDLE;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_port <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE, c_DONE: begin
               if (start) begin
                  r_state     <= c_WR0;
                  r_cnt       <= '0;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_fail_addr <= '0;
                  r_fail_port <= 1'b0;
               end
            end
            c_WR0, c_WR1: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= (r_state == c_WR0) ? c_RD0 : c_RD1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_RD0, c_RD1: begin
               if (w_mismatch) begin
                  r_state     <= c_DONE;
                  r_cnt       <= '0;
                  r_done      <= 1'b1;
                  r_pass      <= 1'b0;
                  r_fail_addr <= w_fail_addr_next;
                  r_fail_port <= w_fail_port_next;
               end else if (w_last) begin
                  r_cnt <= '0;
                  if (r_state == c_RD0) begin
                     r_state <= c_WR1;
                  end else begin
                     r_state     <= c_DONE;
                     r_done      <= 1'b1;
                     r_pass      <= 1'b1;
                     r_fail_addr <= '0;
                     r_fail_port <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bist
// Description : Self-checking bench: behavioural register file with injectable
//               read faults and a march-level outcome model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bist;

   localparam logic [31:0] c_SEED = 32'hA5A5_5A5A;

   logic        clock;
   logic        reset;
   logic        start;
   logic        we3;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  fail_addr;
   logic        fail_port;

   int checks = 0;
   int errors = 0;

   // Fault injection: kind 0 none, 1 stuck bit, 2 word reads zero.
   int       f_kind = 0;
   int       f_reg  = 0;
   int       f_bit  = 0;
   bit       f_val  = 1'b0;
   bit [1:0] f_mask = 2'b00;

   logic [31:0] mem [32];

   regfile_bist dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .ra1       (ra1),
      .ra2       (ra2),
      .rd1       (rd1),
      .rd2       (rd2),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_port (fail_port)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] faulty(input bit port, input int a, input logic [31:0] v);
      logic [31:0] r;
      r = v;
      if (f_kind == 1 && a == f_reg && f_mask[port]) r[f_bit] = f_val;
      if (f_kind == 2 && a == f_reg && f_mask[port]) r = '0;
      return r;
   endfunction

   always @(posedge clock) begin
      if (we3 && wa3 != 5'd0) mem[wa3] <= wd3;
   end

   always_comb begin
      rd1 = faulty(1'b0, int'(ra1), (ra1 == 5'd0) ? 32'h0 : mem[ra1]);
      rd2 = faulty(1'b1, int'(ra2), (ra2 == 5'd0) ? 32'h0 : mem[ra2]);
   end

   function automatic logic [31:0] expv(input int p, input int a);
      if (a == 0) return 32'h0;
      return (p != 0) ? ~(c_SEED ^ 32'(a)) : (c_SEED ^ 32'(a));
   endfunction

   // Port drive expected in cycle n after the start edge: four 32-cycle phases.
   function automatic logic [48:0] drv(input int n);
      int p;
      int c;
      if (n < 1 || n > 128) return '0;
      p = (n - 1) / 32;
      c = (n - 1) % 32;
      if (p % 2 == 0) return {1'b1, 1'b1, 5'(c), expv(p / 2, c), 5'd0, 5'd0};
      return {1'b1, 1'b0, 5'd0, 32'd0, 5'(c), 5'(31 - c)};
   endfunction

   // Outcome of a march over a fault-free store seen through the faulty read ports.
   task automatic predict(output int n, output bit ok, output int fa, output bit fp);
      n  = 129;
      ok = 1'b1;
      fa = 0;
      fp = 1'b0;
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 32; c++) begin
            if (faulty(1'b0, c, expv(p, c)) !== expv(p, c)) begin
               n = p * 64 + 32 + c + 2; ok = 1'b0; fa = c; fp = 1'b0;
               return;
            end
            if (faulty(1'b1, 31 - c, expv(p, 31 - c)) !== expv(p, 31 - c)) begin
               n = p * 64 + 32 + c + 2; ok = 1'b0; fa = 31 - c; fp = 1'b1;
               return;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run(input int exp_n, input bit exp_ok, input int exp_fa, input bit exp_fp,
                      input int inj_n);
      int n;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      chk("done_clr", 64'({done, pass}), 64'd0);
      while (done !== 1'b1 && n < 300) begin
         if (n < exp_n) chk("drive", 64'({busy, we3, wa3, wd3, ra1, ra2}), 64'(drv(n)));
         start = (n == inj_n);
         tick();
         n++;
      end
      start = 1'b0;
      chk("done_cycle", 64'(n), 64'(exp_n));
      chk("pass", 64'(pass), 64'(exp_ok));
      chk("fail_addr", 64'(fail_addr), 64'(exp_fa));
      chk("fail_port", 64'(fail_port), 64'(exp_fp));
      chk("idle_drive", 64'({busy, we3, wa3, wd3, ra1, ra2}), 64'd0);
   endtask

   initial begin
      int en;
      bit eok;
      int efa;
      bit efp;

      reset = 1'b1;
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (20) begin
         tick();
         chk("reset_idle", 64'({busy, we3, wa3, wd3, ra1, ra2, done, pass, fail_addr, fail_port}),
             64'd0);
      end

      // Clean run from IDLE
      f_kind = 0;
      predict(en, eok, efa, efp);
      run(en, eok, efa, efp, -1);

      // Bit 3 of register 9 stuck at 0 on both ports
      f_kind = 1; f_reg = 9; f_bit = 3; f_val = 1'b0; f_mask = 2'b11;
      predict(en, eok, efa, efp);
      run(en, eok, efa, efp, -1);

      // Read port 2 returns zero for address 30
      f_kind = 2; f_reg = 30; f_mask = 2'b10;
      predict(en, eok, efa, efp);
      run(en, eok, efa, efp, -1);

      // Reset in RD0 at cnt=12, then a full clean run
      f_kind = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (44) tick();
      chk("rd0_cnt12", 64'({busy, we3, ra1, ra2}), 64'({1'b1, 1'b0, 5'd12, 5'd19}));
      reset = 1'b1;
      tick();
      chk("after_reset", 64'({busy, we3, done}), 64'd0);
      reset = 1'b0;
      predict(en, eok, efa, efp);
      run(en, eok, efa, efp, -1);

      // start during WR1 is ignored; then a restart from DONE
      run(en, eok, efa, efp, 70);
      run(en, eok, efa, efp, -1);

      // Randomised fault campaign with random idle gaps and stray starts
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 4)) tick();
         f_kind = int'($urandom_range(0, 2));
         f_reg  = int'($urandom_range(1, 31));
         f_bit  = int'($urandom_range(0, 31));
         f_val  = 1'($urandom_range(0, 1));
         f_mask = 2'($urandom_range(1, 3));
         predict(en, eok, efa, efp);
         run(en, eok, efa, efp, int'($urandom_range(2, 128)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
